elevator_scan: RTL and testbench

Parametrised single-car elevator controller for an N-floor shaft. It accepts floor requests through a valid/ready port and keeps every outstanding request in a pending bitmap. Requests are served in SCAN (sweep) order. Door open/close timing comes from an internal door sequencer. The block sits between the hall/car call encoders and the motor/door drivers, and supersedes the fixed five-floor, single-request controller.

---
 rtl/elevator_pkg.sv | 28 ++
 rtl/door_sequencer.sv | 80 ++++++++
 rtl/elevator_scan.sv | 160 ++++++++++++++++
 tb/tb_elevator_scan.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and pending-bitmap search helpers for elevator_scan
package elevator_pkg;

  // Helpers take the bitmap zero-extended to this width, so NUM_FLOORS must not exceed it.
  localparam int MAX_FLOORS = 64;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;
  typedef enum logic {UP, DOWN} dir_e;
  typedef enum logic [1:0] {CLOSED, OPENING, CLOSING} door_phase_e;

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend, input int unsigned floor);
    logic [MAX_FLOORS-1:0] upto;
    upto = (MAX_FLOORS'(2) << floor) - MAX_FLOORS'(1);
    return |(pend & ~upto);
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend, input int unsigned floor);
    logic [MAX_FLOORS-1:0] below;
    below = (MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1);
    return |(pend & below);
  endfunction

  function automatic logic any_ahead(input logic [MAX_FLOORS-1:0] pend, input int unsigned floor,
                                     input dir_e dir);
    return (dir == UP) ? any_above(pend, floor) : any_below(pend, floor);
  endfunction

endpackage

// File: rtl/door_sequencer.sv
// rtl/door_sequencer.sv - door open/close timer with emergency hold and reopen
module door_sequencer
  import elevator_pkg::*;
#(
  parameter int DOOR_OPEN_CYCLES  = 4,
  parameter int DOOR_CLOSE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold_open,
  input  logic reopen,
  output logic dooropen,
  output logic doorclose,
  output logic done
);

  localparam int MAX_CNT = (DOOR_OPEN_CYCLES > DOOR_CLOSE_CYCLES) ? DOOR_OPEN_CYCLES : DOOR_CLOSE_CYCLES;
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(DOOR_CLOSE_CYCLES - 1);

  door_phase_e phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= CLOSED;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (phase_q)
      CLOSED: begin
        if (start) begin
          phase_d = OPENING;
          cnt_d   = '0;
        end
      end
      OPENING: begin
        if (cnt_q == OPEN_LAST) begin
          phase_d = CLOSING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLOSING: begin
        if (cnt_q == CLOSE_LAST) begin
          phase_d = CLOSED;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        phase_d = CLOSED;
        cnt_d   = '0;
      end
    endcase
    // Reopen and emergency hold both restart a full open period.
    if ((reopen && phase_q == CLOSING) || hold_open) begin
      phase_d = OPENING;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

  assign dooropen  = (phase_q == OPENING);
  assign doorclose = !dooropen;

endmodule

// File: rtl/elevator_scan.sv
// rtl/elevator_scan.sv - N-floor SCAN elevator controller with pending-request bitmap
module elevator_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS        = 8,
  parameter int TRAVEL_CYCLES     = 3,
  parameter int DOOR_OPEN_CYCLES  = 4,
  parameter int DOOR_CLOSE_CYCLES = 2,
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_ready,
  input  logic                  emergency_stop,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  dooropen,
  output logic                  doorclose,
  output logic                  idle,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TRAVEL_W-1:0]   travel_q, travel_d;
  logic                  door_first_q, door_first_d;
  logic                  moving_up_q, moving_up_d;
  logic                  moving_down_q, moving_down_d;

  logic                  accept, in_range, reopen, door_done, hold_open;
  logic [FLOOR_W-1:0]    next_floor;
  logic [NUM_FLOORS-1:0] set_mask, clear_mask;
  logic [MAX_FLOORS-1:0] pend_wide;
  dir_e                  dir_flip;

  assign req_ready = !emergency_stop;
  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_floor) < NUM_FLOORS;
  assign pend_wide = MAX_FLOORS'(pending_q);
  assign dir_flip  = (dir_q == UP) ? DOWN : UP;
  assign hold_open = emergency_stop && (state_q == DOOR);
  // Only a request landing in the close phase reopens; the sequencer ignores it otherwise.
  assign reopen    = (state_q == DOOR) && !door_first_q && accept && (req_floor == floor_q);

  door_sequencer #(
    .DOOR_OPEN_CYCLES (DOOR_OPEN_CYCLES),
    .DOOR_CLOSE_CYCLES(DOOR_CLOSE_CYCLES)
  ) u_door (
    .clk      (clk),
    .reset    (reset),
    .start    (door_first_q),
    .hold_open(hold_open),
    .reopen   (reopen),
    .dooropen (dooropen),
    .doorclose(doorclose),
    .done     (door_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      dir_q         <= UP;
      floor_q       <= '0;
      pending_q     <= '0;
      travel_q      <= '0;
      door_first_q  <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      floor_q       <= floor_d;
      pending_q     <= pending_d;
      travel_q      <= travel_d;
      door_first_q  <= door_first_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
    end
  end

  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    // Requests for the floor being served are absorbed for the whole stop.
    if (accept && in_range && !(state_q == DOOR && req_floor == floor_q))
      set_mask = NUM_FLOORS'(1) << req_floor;
    if (door_first_q)
      clear_mask = NUM_FLOORS'(1) << floor_q;
    pending_d = (pending_q | set_mask) & ~clear_mask;
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    floor_d    = floor_q;
    travel_d   = travel_q;
    next_floor = (dir_q == UP) ? floor_q + 1'b1 : floor_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (!emergency_stop) begin
          if (pending_q[floor_q]) begin
            state_d = DOOR;
          end else if (any_above(pend_wide, 32'(floor_q))) begin
            state_d = MOVE;
            dir_d   = UP;
          end else if (any_below(pend_wide, 32'(floor_q))) begin
            state_d = MOVE;
            dir_d   = DOWN;
          end
        end
      end
      MOVE: begin
        if (!emergency_stop) begin
          if (travel_q == TRAVEL_LAST) begin
            travel_d = '0;
            floor_d  = next_floor;
            if (pending_q[next_floor])
              state_d = DOOR;
            else if (!any_ahead(pend_wide, 32'(next_floor), dir_q))
              state_d = IDLE;
          end else begin
            travel_d = travel_q + 1'b1;
          end
        end
      end
      DOOR: begin
        if (door_done) begin
          if (any_ahead(pend_wide, 32'(floor_q), dir_q)) begin
            state_d = MOVE;
          end else if (any_ahead(pend_wide, 32'(floor_q), dir_flip)) begin
            state_d = MOVE;
            dir_d   = dir_flip;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    door_first_d  = (state_d == DOOR) && (state_q != DOOR);
    // Motor drive is registered and drops on the arrival edge.
    moving_up_d   = (state_q == MOVE) && (state_d == MOVE) && (dir_q == UP) && !emergency_stop;
    moving_down_d = (state_q == MOVE) && (state_d == MOVE) && (dir_q == DOWN) && !emergency_stop;
  end

  assign current_floor = floor_q;
  assign moving_up     = moving_up_q;
  assign moving_down   = moving_down_q;
  assign idle          = (state_q == IDLE) && (pending_q == '0);
  assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_scan.sv
// tb/tb_elevator_scan.sv - directed self-checking bench for elevator_scan
module tb_elevator_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_floor;
  logic       req_ready;
  logic       emergency_stop;
  logic [2:0] current_floor;
  logic       moving_up, moving_down, dooropen, doorclose, idle;
  logic [7:0] pending;

  logic       req_valid5;
  logic [2:0] req_floor5;
  logic       req_ready5;
  logic [2:0] floor5;
  logic       up5, down5, open5, close5, idle5;
  logic [4:0] pending5;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  elevator_scan #(
    .NUM_FLOORS(8), .TRAVEL_CYCLES(3), .DOOR_OPEN_CYCLES(4), .DOOR_CLOSE_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .emergency_stop(emergency_stop), .current_floor(current_floor),
    .moving_up(moving_up), .moving_down(moving_down), .dooropen(dooropen),
    .doorclose(doorclose), .idle(idle), .pending(pending)
  );

  // Five-floor car: the 3-bit request port can carry out-of-range floors 5..7.
  elevator_scan #(
    .NUM_FLOORS(5), .TRAVEL_CYCLES(3), .DOOR_OPEN_CYCLES(4), .DOOR_CLOSE_CYCLES(2)
  ) dut5 (
    .clk(clk), .reset(reset), .req_valid(req_valid5), .req_floor(req_floor5),
    .req_ready(req_ready5), .emergency_stop(emergency_stop), .current_floor(floor5),
    .moving_up(up5), .moving_down(down5), .dooropen(open5),
    .doorclose(close5), .idle(idle5), .pending(pending5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] fl);
    req_floor = fl;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_stop(input string tag, output logic [2:0] fl);
    int n = 0;
    while (dooropen === 1'b1 && n < 200) begin tick(1); n++; end
    while (dooropen !== 1'b1 && n < 200) begin tick(1); n++; end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
    fl = current_floor;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (idle !== 1'b1 && n < 200) begin tick(1); n++; end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    logic [2:0] fl;
    int n;
    reset = 1'b0; req_valid = 1'b0; req_floor = '0; emergency_stop = 1'b0;
    req_valid5 = 1'b0; req_floor5 = '0;
    tick(2);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_doorclose", 32'(doorclose), 32'd1);
    check("rst_dooropen", 32'(dooropen), 32'd0);
    reset = 1'b1;
    tick(20);
    check("idle20_idle", 32'(idle), 32'd1);
    check("idle20_floor", 32'(current_floor), 32'd0);
    check("idle20_pending", 32'(pending), 32'd0);
    check("idle20_ready", 32'(req_ready), 32'd1);
    check("idle20_motor", 32'({moving_up, moving_down}), 32'd0);

    // Floor 0 -> 5: accept at edge t.
    request(3'd5);
    check("f5_pending", 32'(pending), 32'h20);
    check("f5_notidle", 32'(idle), 32'd0);
    tick(1);
    check("f5_up_t1", 32'(moving_up), 32'd0);
    tick(1);
    check("f5_up_t2", 32'(moving_up), 32'd1);
    check("f5_down_t2", 32'(moving_down), 32'd0);
    tick(13);
    check("f5_floor_t15", 32'(current_floor), 32'd4);
    tick(1);
    check("f5_floor_t16", 32'(current_floor), 32'd5);
    check("f5_up_t16", 32'(moving_up), 32'd0);
    check("f5_open_t16", 32'(dooropen), 32'd0);
    tick(1);
    check("f5_open_t17", 32'(dooropen), 32'd1);
    check("f5_clear_t17", 32'(pending), 32'd0);
    tick(3);
    check("f5_open_t20", 32'(dooropen), 32'd1);
    tick(1);
    check("f5_open_t21", 32'(dooropen), 32'd0);
    check("f5_close_t21", 32'(doorclose), 32'd1);
    tick(1);
    check("f5_idle_t22", 32'(idle), 32'd0);
    tick(1);
    check("f5_idle_t23", 32'(idle), 32'd1);

    // Down to 0, then sweep up from 0 with requests added at floor 2.
    request(3'd0);
    wait_stop("scan_s0", fl);
    check("scan_s0_floor", 32'(fl), 32'd0);
    wait_idle("scan_idle0");
    request(3'd6);
    n = 0;
    while (current_floor !== 3'd2 && n < 100) begin tick(1); n++; end
    check("scan_at2_timeout", 32'(n < 100), 32'd1);
    request(3'd4);
    request(3'd0);
    check("scan_pending", 32'(pending), 32'h51);
    wait_stop("scan_s1", fl);
    check("scan_s1_floor", 32'(fl), 32'd4);
    wait_stop("scan_s2", fl);
    check("scan_s2_floor", 32'(fl), 32'd6);
    n = 0;
    while (moving_up !== 1'b1 && moving_down !== 1'b1 && n < 100) begin tick(1); n++; end
    check("scan_flip_timeout", 32'(n < 100), 32'd1);
    check("scan_flip_down", 32'({moving_up, moving_down}), 32'd1);
    wait_stop("scan_s3", fl);
    check("scan_s3_floor", 32'(fl), 32'd0);
    wait_idle("scan_idle_end");
    check("scan_pending_end", 32'(pending), 32'd0);

    // Emergency stop for 5 cycles mid-travel from 0 to 2.
    request(3'd2);
    tick(2);
    emergency_stop = 1'b1;
    #1;
    check("estop_ready", 32'(req_ready), 32'd0);
    tick(4);
    check("estop_motor", 32'({moving_up, moving_down}), 32'd0);
    check("estop_floor", 32'(current_floor), 32'd0);
    check("estop_ready_late", 32'(req_ready), 32'd0);
    tick(1);
    emergency_stop = 1'b0;
    tick(2);
    check("estop_floor_t9", 32'(current_floor), 32'd1);
    tick(2);
    check("estop_floor_t11", 32'(current_floor), 32'd1);
    check("estop_up_t11", 32'(moving_up), 32'd1);
    tick(1);
    check("estop_floor_t12", 32'(current_floor), 32'd2);

    // Same-floor request during close phase reopens the door.
    tick(5);
    check("reopen_closing", 32'(doorclose), 32'd1);
    request(3'd2);
    check("reopen_open", 32'(dooropen), 32'd1);
    check("reopen_pending", 32'(pending), 32'd0);
    tick(3);
    check("reopen_open_4th", 32'(dooropen), 32'd1);
    tick(1);
    check("reopen_closed", 32'(dooropen), 32'd0);
    tick(1);
    check("reopen_busy", 32'(idle), 32'd0);
    tick(1);
    check("reopen_idle", 32'(idle), 32'd1);

    // Out-of-range floors on the five-floor car are dropped.
    req_floor5 = 3'd7; req_valid5 = 1'b1;
    tick(1);
    req_floor5 = 3'd5;
    tick(1);
    req_valid5 = 1'b0;
    check("oor_pending", 32'(pending5), 32'd0);
    tick(2);
    check("oor_idle", 32'(idle5), 32'd1);
    check("oor_floor", 32'(floor5), 32'd0);
    req_floor5 = 3'd4; req_valid5 = 1'b1;
    tick(1);
    req_valid5 = 1'b0;
    check("oor_inrange", 32'(pending5), 32'h10);

    // Reset while the door is open.
    request(3'd2);
    request(3'd6);
    tick(1);
    check("rstdoor_open", 32'(dooropen), 32'd1);
    check("rstdoor_pending", 32'(pending), 32'h40);
    reset = 1'b0;
    tick(1);
    check("rstdoor_floor", 32'(current_floor), 32'd0);
    check("rstdoor_pending0", 32'(pending), 32'd0);
    check("rstdoor_idle", 32'(idle), 32'd1);
    check("rstdoor_doors", 32'({dooropen, doorclose}), 32'd1);
    check("rstdoor_motor", 32'({moving_up, moving_down}), 32'd0);
    check("rstdoor_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    tick(3);
    check("rstdoor_stays_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
